seq_div: RTL and testbench
==========================

# seq_div

Multi-cycle, parametrised integer divider for the CPU's MULT/DIV unit. It produces the quotient into `lo` and the remainder into `hi`, matching MIPS DIV/DIVU semantics. It uses an iterative restoring algorithm at one quotient bit per cycle, with a start/done handshake toward the control unit. It flags divide-by-zero, which the control unit uses to raise the arithmetic exception.

## Interface
Parameters:
- `WIDTH`, default 32: operand and result width in bits; must be ≥ 2.

Ports:
- `clk`, input, 1: clock. All state updates on the rising edge.
- `reset`, input, 1: reset, synchronous, active-high. Clock is `clk`.
- `start`, input, 1: request a division. Accepted only when `busy` = 0.
- `signed_op`, input, 1: 1 = DIV (signed), 0 = DIVU. Sampled with `start`.
- `dividend`, input, `WIDTH`: numerator. Sampled with `start`.
- `divisor`, input, `WIDTH`: denominator. Sampled with `start`.
- `busy`, output, 1: operation in progress.
- `done`, output, 1: single-cycle pulse; `lo`, `hi`, `div_zero` are valid from this cycle on.
- `lo`, output, `WIDTH`: quotient.
- `hi`, output, `WIDTH`: remainder.
- `div_zero`, output, 1: last operation had `divisor` == 0.

## Operation
- FSM states:
  - IDLE.
  - CALC: iterate; a counter runs from `WIDTH-1` down to 0.
  - FIX: sign correction and result load.
  - DONE: pulse `done`, then return to IDLE.
- IDLE → CALC on `start`:
  - Latch the operands.
  - If signed, store their magnitudes and record `q_neg = sign(a) ^ sign(b)` and `r_neg = sign(a)`.
  - Clear the partial remainder.
- IDLE → FIX directly when `divisor` == 0. This skips CALC.
- CALC, each cycle:
  - Shift `{rem, quo}` left by 1.
  - Trial subtract the divisor, using a `WIDTH+1`-bit subtractor.
  - If the result is non-negative, keep it and set the quotient LSB to 1.
  - When the counter reaches 0, go to FIX.
- FIX:
  - Negate the quotient if `q_neg`; negate the remainder if `r_neg`.
  - Write `lo`/`hi`/`div_zero`, then go to DONE.
- Division semantics:
  - Quotient truncates toward zero; the remainder takes the dividend's sign.
  - |`hi`| < |`divisor`|.
- Divide by zero: `lo` = all ones, `hi` = `dividend`, `div_zero` = 1. This is not an error inside the block.
- Signed overflow, MIN / −1: `lo` = MIN, `hi` = 0, `div_zero` = 0. This falls out of the magnitude path with no special case.
- Handshakes:
  - `start` while `busy` = 1 is ignored. No queueing, and the operation in flight is unaffected.
  - `lo`/`hi`/`div_zero` hold their values until the next FIX. They are not cleared by a new `start`.
- Reset:
  - Reset values: all outputs 0, state IDLE, counter 0.
  - Reset mid-operation aborts the operation with no `done` pulse.
  - Reset has priority over `start` in the same cycle.

## Timing
- Call the edge at which `start` is accepted edge 0.
- `busy` = 1 from edge 0 until the edge on which `done` falls. `busy` = 0 in the `done` cycle, so a new `start` may be issued while `done` = 1.
- Normal latency: CALC occupies edges 1..`WIDTH`, FIX is edge `WIDTH`+1, and `done` is high for exactly one cycle after edge `WIDTH`+2. That is 34 cycles for `WIDTH` = 32.
- Divide-by-zero latency: FIX at edge 1, `done` high after edge 2.
- The latency is fixed and independent of operand values. There is no early termination.

## Configuration
- Macro: `SEQ_DIV_SIGNED_EN`.
- Defined: `signed_op` is honoured, and the sign-capture and FIX negation logic are built.
- Undefined:
  - `signed_op` is ignored and all operations are unsigned.
  - FIX only loads results; latency is unchanged.
  - MIN / −1 is treated as unsigned division.

## Structure
- Shared package `div_pkg`:
  - `DIV_WIDTH_DEFAULT` = 32.
  - `div_state_t` enum {IDLE, CALC, FIX, DONE}.
  - Counter width `$clog2(WIDTH)` is computed locally.
- One sub-module, `div_step`: a combinational single-iteration shift/trial-subtract taking `rem`, `quo`, `divisor` and returning the next `rem`/`quo`. The FSM, counter and sign handling stay in the top level.

## Test plan
- Unsigned, `WIDTH` = 32: 100 / 7 → `lo` = 14, `hi` = 2, `div_zero` = 0. `done` pulses exactly once, after edge 34.
- Signed (macro on):
  - −7 / 2 → `lo` = −3, `hi` = −1.
  - 7 / −2 → `lo` = −3, `hi` = 1.
  - 0x80000000 / −1 → `lo` = 0x80000000, `hi` = 0.
- Divide by zero: 55 / 0 → `lo` = 0xFFFFFFFF, `hi` = 55, `div_zero` = 1, `done` after edge 2. A following 9 / 3 clears `div_zero` and gives `lo` = 3.
- Start while busy: a second `start` with 8 / 2 at edge 5 is ignored. Results match the first operation only, with one `done`.
- Reset at edge 10 mid-operation: no `done` pulse, all outputs 0, `busy` = 0. A new `start` at the next edge completes normally.
- Back-to-back and regression:
  - A `start` issued in the `done` cycle is accepted.
  - `WIDTH` = 8 random sweep against a reference model, in both macro builds.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: default width and FSM state encoding.
package div_pkg;

  localparam int DIV_WIDTH_DEFAULT = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift {rem, quo} left by one, trial subtract the divisor.
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_divisor,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_diff;
  logic           w_ge;

  // rem < divisor on entry, so bit WIDTH of the difference is a reliable sign
  assign w_shift = {i_rem, i_quo[WIDTH-1]};
  assign w_diff  = w_shift - {1'b0, i_divisor};
  assign w_ge    = ~w_diff[WIDTH];

  assign o_rem = w_ge ? w_diff[WIDTH-1:0] : w_shift[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], w_ge};

endmodule

// File: rtl/seq_div.sv
// Iterative restoring divider (quotient -> lo, remainder -> hi), MIPS DIV/DIVU semantics.
// Signed operation is built only when SEQ_DIV_SIGNED_EN is defined.
module seq_div
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             signed_op,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             div_zero
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  div_state_t       r_state;
  div_state_t       w_state;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] w_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] w_quo;
  logic [WIDTH-1:0] r_dsr;
  logic [WIDTH-1:0] w_dsr;
  logic             r_zero;
  logic             w_zero;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] w_lo;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] w_hi;
  logic             r_div_zero;
  logic             w_div_zero;
  logic             r_busy;
  logic             r_done;

  logic             w_accept;
  logic             w_b_zero;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic [WIDTH-1:0] w_fix_lo;
  logic [WIDTH-1:0] w_fix_hi;
  logic [WIDTH-1:0] w_step_rem;
  logic [WIDTH-1:0] w_step_quo;

  assign w_accept = (r_state == IDLE) && start;
  assign w_b_zero = (divisor == {WIDTH{1'b0}});

`ifdef SEQ_DIV_SIGNED_EN
  logic r_q_neg;
  logic r_r_neg;

  function automatic logic [WIDTH-1:0] neg2c(input logic [WIDTH-1:0] v);
    return ~v + WIDTH'(1);
  endfunction

  assign w_a_neg  = signed_op & dividend[WIDTH-1];
  assign w_b_neg  = signed_op & divisor[WIDTH-1];
  assign w_a_mag  = w_a_neg ? neg2c(dividend) : dividend;
  assign w_b_mag  = w_b_neg ? neg2c(divisor) : divisor;
  assign w_fix_lo = r_q_neg ? neg2c(r_quo) : r_quo;
  assign w_fix_hi = r_r_neg ? neg2c(r_rem) : r_rem;

  // Sign flags; the quotient keeps its all-ones pattern on divide-by-zero
  always_ff @(posedge clk) begin
    if (reset) begin
      r_q_neg <= 1'b0;
      r_r_neg <= 1'b0;
    end else if (w_accept) begin
      r_q_neg <= (w_a_neg ^ w_b_neg) & ~w_b_zero;
      r_r_neg <= w_a_neg;
    end
  end
`else
  logic w_unused_signed_op;

  assign w_unused_signed_op = signed_op;
  assign w_a_neg  = 1'b0;
  assign w_b_neg  = 1'b0;
  assign w_a_mag  = dividend;
  assign w_b_mag  = divisor;
  assign w_fix_lo = r_quo;
  assign w_fix_hi = r_rem;
`endif

  div_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .i_rem    (r_rem),
    .i_quo    (r_quo),
    .i_divisor(r_dsr),
    .o_rem    (w_step_rem),
    .o_quo    (w_step_quo)
  );

  // Next-state and datapath update for every FSM state
  always_comb begin
    w_state    = r_state;
    w_cnt      = r_cnt;
    w_rem      = r_rem;
    w_quo      = r_quo;
    w_dsr      = r_dsr;
    w_zero     = r_zero;
    w_lo       = r_lo;
    w_hi       = r_hi;
    w_div_zero = r_div_zero;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_dsr  = w_b_mag;
          w_zero = w_b_zero;
          if (w_b_zero) begin
            // dividend parks in rem so FIX returns it unchanged in hi
            w_rem   = w_a_mag;
            w_quo   = {WIDTH{1'b1}};
            w_cnt   = {CNT_W{1'b0}};
            w_state = FIX;
          end else begin
            w_rem   = {WIDTH{1'b0}};
            w_quo   = w_a_mag;
            w_cnt   = CNT_LAST;
            w_state = CALC;
          end
        end else begin
          w_state = IDLE;
        end
      end
      CALC: begin
        w_rem = w_step_rem;
        w_quo = w_step_quo;
        if (r_cnt == {CNT_W{1'b0}}) begin
          w_state = FIX;
        end else begin
          w_cnt   = r_cnt - CNT_W'(1);
          w_state = CALC;
        end
      end
      FIX: begin
        w_lo       = w_fix_lo;
        w_hi       = w_fix_hi;
        w_div_zero = r_zero;
        w_state    = DONE;
      end
      DONE: begin
        w_state = IDLE;
      end
      default: begin
        w_state = IDLE;
      end
    endcase
  end

  // State, datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= {CNT_W{1'b0}};
      r_rem      <= {WIDTH{1'b0}};
      r_quo      <= {WIDTH{1'b0}};
      r_dsr      <= {WIDTH{1'b0}};
      r_zero     <= 1'b0;
      r_lo       <= {WIDTH{1'b0}};
      r_hi       <= {WIDTH{1'b0}};
      r_div_zero <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_cnt      <= w_cnt;
      r_rem      <= w_rem;
      r_quo      <= w_quo;
      r_dsr      <= w_dsr;
      r_zero     <= w_zero;
      r_lo       <= w_lo;
      r_hi       <= w_hi;
      r_div_zero <= w_div_zero;
      r_busy     <= (w_state != IDLE);
      r_done     <= (r_state == DONE);
    end
  end

  assign busy     = r_busy;
  assign done     = r_done;
  assign lo       = r_lo;
  assign hi       = r_hi;
  assign div_zero = r_div_zero;

endmodule

// File: tb/tb_seq_div.sv
// Directed self-checking bench for seq_div (WIDTH 32 and WIDTH 8 instances).
module tb_seq_div;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic        start, signed_op, busy, done, div_zero;
  logic [31:0] dividend, divisor, lo, hi;

  logic        start8, sop8, busy8, done8, dz8;
  logic [7:0]  dvd8, dvs8, lo8, hi8;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int done_cnt = 0;
  int t0       = 0;
  int d0       = 0;

  seq_div #(.WIDTH(32)) u_dut32 (
    .clk(clk), .reset(reset), .start(start), .signed_op(signed_op),
    .dividend(dividend), .divisor(divisor), .busy(busy), .done(done),
    .lo(lo), .hi(hi), .div_zero(div_zero)
  );

  seq_div #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .signed_op(sop8),
    .dividend(dvd8), .divisor(dvs8), .busy(busy8), .done(done8),
    .lo(lo8), .hi(hi8), .div_zero(dz8)
  );

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (done) done_cnt <= done_cnt + 1;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  task automatic launch(input logic [31:0] a, input logic [31:0] b, input logic s);
    dividend  = a;
    divisor   = b;
    signed_op = s;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    t0    = cyc;
  endtask

  task automatic wait_done(input int lat, input string tag);
    int k = 0;
    while (!done && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_eq({tag, "_lat"}, 64'(cyc - t0), 64'(lat));
  endtask

  task automatic run(input logic [31:0] a, input logic [31:0] b, input logic s, input int lat,
                     input logic [31:0] elo, input logic [31:0] ehi, input logic edz,
                     input string tag);
    d0 = done_cnt;
    launch(a, b, s);
    check_eq({tag, "_busy"}, 64'(busy), 64'd1);
    wait_done(lat, tag);
    check_eq({tag, "_lo"}, 64'(lo), 64'(elo));
    check_eq({tag, "_hi"}, 64'(hi), 64'(ehi));
    check_eq({tag, "_dz"}, 64'(div_zero), 64'(edz));
    check_eq({tag, "_busy_done"}, 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    check_eq({tag, "_ndone"}, 64'(done_cnt - d0), 64'd1);
  endtask

  task automatic op8(input logic [7:0] a, input logic [7:0] b, input logic s, input int lat,
                     input logic [7:0] elo, input logic [7:0] ehi, input logic edz,
                     input string tag);
    int k = 0;
    dvd8   = a;
    dvs8   = b;
    sop8   = s;
    start8 = 1'b1;
    @(posedge clk);
    #1;
    start8 = 1'b0;
    while (!done8 && k < 50) begin
      @(posedge clk);
      #1;
      k++;
    end
    check_eq({tag, "_lat"}, 64'(k), 64'(lat));
    check_eq({tag, "_lo"}, 64'(lo8), 64'(elo));
    check_eq({tag, "_hi"}, 64'(hi8), 64'(ehi));
    check_eq({tag, "_dz"}, 64'(dz8), 64'(edz));
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; signed_op = 1'b0; dividend = 32'd0; divisor = 32'd0;
    start8 = 1'b0; sop8 = 1'b0; dvd8 = 8'd0; dvs8 = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_lo", 64'(lo), 64'd0);
    check_eq("rst_hi", 64'(hi), 64'd0);
    check_eq("rst_dz", 64'(div_zero), 64'd0);
    check_eq("rst_busy", 64'(busy), 64'd0);
    check_eq("rst_done", 64'(done), 64'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run(32'd100, 32'd7, 1'b0, 34, 32'd14, 32'd2, 1'b0, "u100_7");
`ifdef SEQ_DIV_SIGNED_EN
    run(32'hFFFFFFF9, 32'd2, 1'b1, 34, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, "s_m7_2");
    run(32'd7, 32'hFFFFFFFE, 1'b1, 34, 32'hFFFFFFFD, 32'd1, 1'b0, "s_7_m2");
    run(32'h80000000, 32'hFFFFFFFF, 1'b1, 34, 32'h80000000, 32'd0, 1'b0, "s_min_m1");
`else
    run(32'hFFFFFFF9, 32'd2, 1'b1, 34, 32'h7FFFFFFC, 32'd1, 1'b0, "s_m7_2");
    run(32'd7, 32'hFFFFFFFE, 1'b1, 34, 32'd0, 32'd7, 1'b0, "s_7_m2");
    run(32'h80000000, 32'hFFFFFFFF, 1'b1, 34, 32'd0, 32'h80000000, 1'b0, "s_min_m1");
`endif
    run(32'hFFFFFFF9, 32'd2, 1'b0, 34, 32'h7FFFFFFC, 32'd1, 1'b0, "u_f9_2");
    run(32'd55, 32'd0, 1'b0, 2, 32'hFFFFFFFF, 32'd55, 1'b1, "dz55");
    run(32'd9, 32'd3, 1'b0, 34, 32'd3, 32'd0, 1'b0, "after_dz");
    run(32'hFFFFFFFB, 32'd0, 1'b1, 2, 32'hFFFFFFFF, 32'hFFFFFFFB, 1'b1, "dz_neg");

    // start while busy is ignored
    d0 = done_cnt;
    launch(32'd1000, 32'd10, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    dividend = 32'd8; divisor = 32'd2; start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(34, "busy_ign");
    check_eq("busy_ign_lo", 64'(lo), 64'd100);
    check_eq("busy_ign_hi", 64'(hi), 64'd0);
    repeat (4) @(posedge clk);
    #1;
    check_eq("busy_ign_idle", 64'(busy), 64'd0);
    check_eq("busy_ign_ndone", 64'(done_cnt - d0), 64'd1);

    // reset at edge 10 aborts, then a new start at edge 11
    d0 = done_cnt;
    launch(32'd100, 32'd7, 1'b0);
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_eq("abort_lo", 64'(lo), 64'd0);
    check_eq("abort_hi", 64'(hi), 64'd0);
    check_eq("abort_busy", 64'(busy), 64'd0);
    check_eq("abort_done", 64'(done), 64'd0);
    launch(32'd77, 32'd5, 1'b0);
    wait_done(34, "post_rst");
    check_eq("post_rst_lo", 64'(lo), 64'd15);
    check_eq("post_rst_hi", 64'(hi), 64'd2);
    @(posedge clk);
    #1;
    check_eq("abort_ndone", 64'(done_cnt - d0), 64'd1);

    // reset wins over start in the same cycle
    reset = 1'b1; dividend = 32'd9; divisor = 32'd3; start = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0; start = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_prio_busy", 64'(busy), 64'd0);

    // back-to-back: start issued in the done cycle
    launch(32'd1000, 32'd33, 1'b0);
    wait_done(34, "b2b_a");
    check_eq("b2b_a_lo", 64'(lo), 64'd30);
    check_eq("b2b_a_hi", 64'(hi), 64'd10);
    launch(32'hFFFFFFFF, 32'h00010000, 1'b0);
    check_eq("b2b_b_busy", 64'(busy), 64'd1);
    wait_done(34, "b2b_b");
    check_eq("b2b_b_lo", 64'(lo), 64'h0000FFFF);
    check_eq("b2b_b_hi", 64'(hi), 64'h0000FFFF);

    // WIDTH 8 vectors
    op8(8'd200, 8'd13, 1'b0, 10, 8'd15, 8'd5, 1'b0, "w8_200_13");
    op8(8'd255, 8'd1, 1'b0, 10, 8'd255, 8'd0, 1'b0, "w8_255_1");
    op8(8'd7, 8'd9, 1'b0, 10, 8'd0, 8'd7, 1'b0, "w8_7_9");
    op8(8'hF9, 8'd3, 1'b0, 10, 8'h53, 8'h00, 1'b0, "w8_u_f9_3");
    op8(8'd200, 8'd0, 1'b0, 2, 8'hFF, 8'hC8, 1'b1, "w8_dz");
`ifdef SEQ_DIV_SIGNED_EN
    op8(8'h80, 8'hFF, 1'b1, 10, 8'h80, 8'h00, 1'b0, "w8_s_min");
    op8(8'hF9, 8'h03, 1'b1, 10, 8'hFE, 8'hFF, 1'b0, "w8_s_m7_3");
    op8(8'h64, 8'hF9, 1'b1, 10, 8'hF2, 8'h02, 1'b0, "w8_s_100_m7");
    op8(8'h81, 8'h0A, 1'b1, 10, 8'hF4, 8'hF9, 1'b0, "w8_s_m127_10");
`else
    op8(8'h80, 8'hFF, 1'b1, 10, 8'h00, 8'h80, 1'b0, "w8_s_min");
    op8(8'hF9, 8'h03, 1'b1, 10, 8'h53, 8'h00, 1'b0, "w8_s_m7_3");
    op8(8'h64, 8'hF9, 1'b1, 10, 8'h00, 8'h64, 1'b0, "w8_s_100_m7");
    op8(8'h81, 8'h0A, 1'b1, 10, 8'h0C, 8'h09, 1'b0, "w8_s_m127_10");
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
